// File: rtl/fault_manager_if.sv
// Fault-manager signal bundle between the supervisor/stimulus side and the
// fault manager itself.
//   master : drives fault_in, fault_mask, clear; observes all status outputs
//   slave  : the fault manager; observes requests, drives drive-disable/status
interface fault_manager_if #(
  parameter int unsigned NUM_FAULTS = 4
) ();

  localparam int unsigned CAUSE_W = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1;

  logic [NUM_FAULTS-1:0] fault_in;
  logic [NUM_FAULTS-1:0] fault_mask;
  logic                  clear;

  logic                  fault;
  logic                  lockout;
  logic [NUM_FAULTS-1:0] fault_status;
  logic [CAUSE_W-1:0]    fault_cause;
  logic [3:0]            retry_count;
  logic [1:0]            state;

  modport master (
    output fault_in, fault_mask, clear,
    input  fault, lockout, fault_status, fault_cause, retry_count, state
  );

  modport slave (
    input  fault_in, fault_mask, clear,
    output fault, lockout, fault_status, fault_cause, retry_count, state
  );

endinterface

// File: rtl/fault_manager.sv
// Fault manager for the motor-drive control path: per-channel masking and
// glitch filtering, sticky fault status, and an auto-retry FSM with cooldown
// and lockout driving the registered drive-disable output.
//   clk, rst                 : clock, synchronous active-high reset
//   fm_if.fault_in/mask      : raw fault requests and per-channel ignore mask
//   fm_if.clear              : single-cycle supervisor clear pulse
//   fm_if.fault              : registered drive-disable (1 = drive off)
//   fm_if.lockout            : registered, 1 while in LOCKOUT
//   fm_if.fault_status       : sticky qualified-fault flags
//   fm_if.fault_cause        : lowest qualified channel at the last trip
//   fm_if.retry_count        : trips since last clear/reset
//   fm_if.state              : debug state (RUN=0 TRIP=1 COOLDOWN=2 LOCKOUT=3)
module fault_manager #(
  parameter int unsigned NUM_FAULTS    = 4,
  parameter int unsigned FILTER_CYCLES = 8,
  parameter int unsigned RETRY_DELAY   = 1000,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic           clk,
  input  logic           rst,
  fault_manager_if.slave fm_if
);

  localparam int unsigned CNT_W   = $clog2(FILTER_CYCLES + 1);
  localparam int unsigned TMR_W   = $clog2(RETRY_DELAY + 1);
  localparam int unsigned CAUSE_W = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1;
  localparam int unsigned RETRY_W = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_TRIP     = 2'd1,
    ST_COOLDOWN = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [RETRY_W-1:0]    retry_q, retry_d;
  logic [CAUSE_W-1:0]    cause_q, cause_d;
  logic [NUM_FAULTS-1:0] status_q, status_d;
  logic                  fault_q, fault_d;
  logic                  lockout_q, lockout_d;
  logic [CNT_W-1:0]      cnt_q [NUM_FAULTS];
  logic [CNT_W-1:0]      cnt_d [NUM_FAULTS];

  logic [NUM_FAULTS-1:0] active_c;
  logic [NUM_FAULTS-1:0] qual_c;
  logic [CAUSE_W-1:0]    cause_sel_c;
  logic [RETRY_W-1:0]    retry_base_c;

  assign active_c = fm_if.fault_in & ~fm_if.fault_mask;

  // Glitch filter: saturating run-length counter per channel, cleared by any
  // inactive sample (including a masked one).
  always_comb begin
    cnt_d  = cnt_q;
    qual_c = '0;
    for (int i = 0; i < int'(NUM_FAULTS); i++) begin
      qual_c[i] = (cnt_q[i] == CNT_W'(FILTER_CYCLES));
      if (!active_c[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != CNT_W'(FILTER_CYCLES)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Lowest-numbered qualified channel wins the cause report.
  always_comb begin
    cause_sel_c = '0;
    for (int i = int'(NUM_FAULTS) - 1; i >= 0; i--) begin
      if (qual_c[i]) begin
        cause_sel_c = CAUSE_W'(i);
      end
    end
  end

  // Next-state, retry bookkeeping and registered-output targets.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cause_d   = cause_q;
    fault_d   = fault_q;
    lockout_d = lockout_q;

    // A qualified fault beats a simultaneous clear on the sticky flags.
    status_d = qual_c | (status_q & ~{NUM_FAULTS{fm_if.clear}});

    // Clear zeroes the count first, so a same-cycle trip lands on 1.
    retry_base_c = fm_if.clear ? '0 : retry_q;
    retry_d      = retry_base_c;

    case (state_q)
      ST_RUN: begin
        if (|qual_c) begin
          cause_d = cause_sel_c;
          if (retry_base_c < RETRY_W'(MAX_RETRIES)) begin
            state_d = ST_TRIP;
            retry_d = retry_base_c + RETRY_W'(1);
          end else begin
            state_d = ST_LOCKOUT;
          end
        end
      end

      ST_TRIP: begin
        if (active_c == '0) begin
          state_d = ST_COOLDOWN;
          timer_d = TMR_W'(RETRY_DELAY);
        end
      end

      ST_COOLDOWN: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TMR_W'(1);
        end
        // A returning raw fault restarts the trip before the timer can expire.
        if (active_c != '0) begin
          state_d = ST_TRIP;
        end else if (timer_q == TMR_W'(1)) begin
          state_d = ST_RUN;
        end
      end

      ST_LOCKOUT: begin
        if (fm_if.clear) begin
          state_d = ST_COOLDOWN;
          timer_d = TMR_W'(RETRY_DELAY);
        end
      end

      default: begin
        state_d = ST_LOCKOUT;
      end
    endcase

    fault_d   = (state_d != ST_RUN);
    lockout_d = (state_d == ST_LOCKOUT);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_COOLDOWN;
      timer_q   <= TMR_W'(RETRY_DELAY);
      retry_q   <= '0;
      cause_q   <= '0;
      status_q  <= '0;
      fault_q   <= 1'b1;
      lockout_q <= 1'b0;
      for (int i = 0; i < int'(NUM_FAULTS); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      cause_q   <= cause_d;
      status_q  <= status_d;
      fault_q   <= fault_d;
      lockout_q <= lockout_d;
      for (int i = 0; i < int'(NUM_FAULTS); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign fm_if.fault        = fault_q;
  assign fm_if.lockout      = lockout_q;
  assign fm_if.fault_status = status_q;
  assign fm_if.fault_cause  = cause_q;
  assign fm_if.retry_count  = retry_q;
  assign fm_if.state        = state_q;

endmodule
